// File: rtl/wb_stage.sv
// Writeback stage: registers the retiring instruction, extracts load data and drives the register file write port.
// Optional retired-instruction counter under WB_INSTRET_EN.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_reg_we,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] dmem_dout,
    input  logic            stall,
    input  logic            flush,
    output logic            we,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    logic            w_valid;
    logic            w_reg_we;
    logic [4:0]      w_rd;
    logic [1:0]      w_wb_sel;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_pc4;
    logic [2:0]      w_funct3;
    logic [1:0]      w_addr_lo;

    logic [XLEN-1:0] ld_hold;
    logic            ld_hold_v;
    logic [XLEN-1:0] ld_raw;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid   <= 1'b0;
            w_reg_we  <= 1'b0;
            w_rd      <= '0;
            w_wb_sel  <= '0;
            w_alu     <= '0;
            w_pc4     <= '0;
            w_funct3  <= '0;
            w_addr_lo <= '0;
        end else if (!stall) begin
            if (flush) begin
                w_valid <= 1'b0;
            end else begin
                w_valid   <= in_valid;
                w_reg_we  <= in_reg_we;
                w_rd      <= in_rd;
                w_wb_sel  <= in_wb_sel;
                w_alu     <= in_alu;
                w_pc4     <= in_pc4;
                w_funct3  <= in_funct3;
                w_addr_lo <= in_addr_lo;
            end
        end
    end

    // Memory data is only valid for one cycle; capture it on the first stalled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_hold   <= '0;
            ld_hold_v <= 1'b0;
        end else if (stall) begin
            if (w_valid && !ld_hold_v) begin
                ld_hold   <= dmem_dout;
                ld_hold_v <= 1'b1;
            end
        end else begin
            ld_hold_v <= 1'b0;
        end
    end

    assign ld_raw  = ld_hold_v ? ld_hold : dmem_dout;
    assign ld_byte = ld_raw[{w_addr_lo, 3'b000} +: 8];
    assign ld_half = ld_raw[{w_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = ld_raw;
        case (w_funct3)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = ld_raw;
        endcase
    end

    always_comb begin
        wd = w_alu;
        case (w_wb_sel)
            2'd1:    wd = ld_ext;
            2'd2:    wd = w_pc4;
            default: wd = w_alu;
        endcase
    end

    assign we = w_valid && w_reg_we && (w_rd != 5'd0);
    assign wa = w_rd;

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (w_valid && !stall) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/JAL/load writeback, x0 suppression, flush, stall hold, reset mid-stall.
// Retirement-count checks compile in only when WB_INSTRET_EN is defined.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_reg_we;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] dmem_dout;
    logic        stall;
    logic        flush;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
    logic [63:0] exp_ret;
    logic        m_wv;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_reg_we  (in_reg_we),
        .in_rd      (in_rd),
        .in_wb_sel  (in_wb_sel),
        .in_alu     (in_alu),
        .in_pc4     (in_pc4),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .dmem_dout  (dmem_dout),
        .stall      (stall),
        .flush      (flush),
        .we         (we),
        .wa         (wa),
        .wd         (wd)
`ifdef WB_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; the retirement counter expectation follows the counting rule edge by edge.
    task automatic tick();
        @(posedge clk);
`ifdef WB_INSTRET_EN
        if (rst) begin
            exp_ret = '0;
            m_wv    = 1'b0;
        end else if (!stall) begin
            if (m_wv) exp_ret = exp_ret + 64'd1;
            m_wv = flush ? 1'b0 : in_valid;
        end
`endif
        @(negedge clk);
    endtask

    task automatic chk_ret(input string tag);
`ifdef WB_INSTRET_EN
        chk(tag, instret, exp_ret);
`else
        if (tag.len() < 0) $display("unused %s", tag);
`endif
    endtask

    task automatic issue(input logic v, input logic rwe, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                         input logic [1:0] lo);
        in_valid   = v;
        in_reg_we  = rwe;
        in_rd      = rd;
        in_wb_sel  = sel;
        in_alu     = alu;
        in_pc4     = pc4;
        in_funct3  = f3;
        in_addr_lo = lo;
        tick();
        in_valid   = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] exp;
        string       tag;
    } ld_vec_t;

    ld_vec_t ld_vecs[9] = '{
        '{3'b000, 2'd3, 32'hFFFF_FF80, "lb_lo3"},
        '{3'b100, 2'd1, 32'h0000_007F, "lbu_lo1"},
        '{3'b001, 2'd2, 32'hFFFF_80FF, "lh_lo2"},
        '{3'b101, 2'd0, 32'h0000_7F01, "lhu_lo0"},
        '{3'b001, 2'd3, 32'hFFFF_80FF, "lh_lo3"},
        '{3'b000, 2'd0, 32'h0000_0001, "lb_lo0"},
        '{3'b100, 2'd3, 32'h0000_0080, "lbu_lo3"},
        '{3'b011, 2'd1, 32'h80FF_7F01, "f3_011_raw"},
        '{3'b010, 2'd0, 32'h80FF_7F01, "lw"}
    };

    initial begin
`ifdef WB_INSTRET_EN
        exp_ret = '0;
        m_wv    = 1'b0;
`endif
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_reg_we = 1'b1; in_rd = 5'd17; in_wb_sel = 2'd2;
        in_alu = 32'hAAAA_5555; in_pc4 = 32'h1234_0000; in_funct3 = 3'b001; in_addr_lo = 2'd2;
        dmem_dout = 32'hFFFF_FFFF;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_wa", {59'd0, wa}, 64'd0);
        chk("rst_wd", {32'd0, wd}, 64'd0);
        chk_ret("rst_instret");

        issue(1'b1, 1'b1, 5'd5, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'b010, 2'd0);
        chk("alu_we", {63'd0, we}, 64'd1);
        chk("alu_wa", {59'd0, wa}, 64'd5);
        chk("alu_wd", {32'd0, wd}, {32'd0, 32'hDEAD_BEEF});

        issue(1'b1, 1'b1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'b010, 2'd0);
        chk("x0_we", {63'd0, we}, 64'd0);
        tick();
        chk_ret("x0_instret");

        foreach (ld_vecs[i]) begin
            issue(1'b1, 1'b1, 5'd12, 2'd1, 32'h0BAD_0BAD, 32'h0, ld_vecs[i].f3, ld_vecs[i].lo);
            dmem_dout = 32'h80FF_7F01;
            #1;
            chk(ld_vecs[i].tag, {32'd0, wd}, {32'd0, ld_vecs[i].exp});
        end
        chk("ld_we", {63'd0, we}, 64'd1);

        // LW held across three stalled edges while memory output changes.
        issue(1'b1, 1'b1, 5'd7, 2'd1, 32'h0, 32'h0, 3'b010, 2'd0);
        dmem_dout = 32'h1234_5678;
        stall = 1'b1;
        #1;
        chk("stall_wd0", {32'd0, wd}, {32'd0, 32'h1234_5678});
        chk_ret("stall_instret0");
        for (int i = 0; i < 3; i++) begin
            tick();
            dmem_dout = 32'h0;
            #1;
            chk("stall_wd", {32'd0, wd}, {32'd0, 32'h1234_5678});
            chk("stall_we", {63'd0, we}, 64'd1);
            chk("stall_wa", {59'd0, wa}, 64'd7);
            chk_ret("stall_instret");
        end
        stall = 1'b0;
        tick();
        chk("unstall_we", {63'd0, we}, 64'd0);
        chk_ret("unstall_instret");

        in_valid = 1'b1; in_reg_we = 1'b1; in_rd = 5'd3; in_wb_sel = 2'd0; in_alu = 32'h3333_3333;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_we", {63'd0, we}, 64'd0);

        issue(1'b1, 1'b1, 5'd9, 2'd0, 32'h0000_0055, 32'h0, 3'b000, 2'd0);
        in_valid = 1'b1; in_rd = 5'd10; in_alu = 32'h0000_0066;
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("stflush_wa", {59'd0, wa}, 64'd9);
        chk("stflush_wd", {32'd0, wd}, 64'h55);
        chk("stflush_we", {63'd0, we}, 64'd1);

        issue(1'b1, 1'b1, 5'd1, 2'd2, 32'h0000_BEEF, 32'h0000_1004, 3'b000, 2'd0);
        chk("jal_wd", {32'd0, wd}, 64'h1004);
        chk("jal_wa", {59'd0, wa}, 64'd1);
        chk("jal_we", {63'd0, we}, 64'd1);

        issue(1'b1, 1'b0, 5'd8, 2'd0, 32'h1111_2222, 32'h0, 3'b000, 2'd0);
        chk("nowe_we", {63'd0, we}, 64'd0);

        issue(1'b1, 1'b1, 5'd31, 2'd3, 32'hCAFE_F00D, 32'h0000_2000, 3'b000, 2'd0);
        chk("sel3_wd", {32'd0, wd}, {32'd0, 32'hCAFE_F00D});
        chk("sel3_wa", {59'd0, wa}, 64'd31);
        tick();
        chk_ret("pre_rst_instret");

        issue(1'b1, 1'b1, 5'd4, 2'd0, 32'h0000_0044, 32'h0, 3'b000, 2'd0);
        stall = 1'b1;
        tick();
        chk("rststall_pre_we", {63'd0, we}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        chk("rststall_we", {63'd0, we}, 64'd0);
        chk("rststall_wd", {32'd0, wd}, 64'd0);
        chk_ret("rststall_instret");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
